// File: rtl/fifo_burst_pkg.sv
// Shared types for the FIFO burst reader: FSM state, skid entry, widths.
// Optional timeout flush is enabled by FIFO_BURST_READER_TIMEOUT_EN.
package fifo_burst_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Default entry layout; the top builds the same layout at DATA_WIDTH.
    localparam int ENTRY_DW = 16;

    typedef struct packed {
        logic [ENTRY_DW-1:0] data;
        logic                sop;
        logic                eop;
    } skid_entry_t;

    // Skid buffer holds at most 2 entries, so 0..2 needs 2 bits.
    localparam int SKID_CNT_W = 2;

    // Bits needed for a counter that runs 0..n-1 (never less than 1).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_skid_buf2.sv
// Two-entry in-order valid/ready buffer with a registered occupancy count.
// The writer must only enqueue while count < 2.
module fifo_skid_buf2
    import fifo_burst_pkg::*;
#(
    parameter type entry_t = skid_entry_t
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  entry_t                in_entry,
    output logic                  out_valid,
    output entry_t                out_entry,
    input  logic                  out_ready,
    output logic [SKID_CNT_W-1:0] count
);

    entry_t head;
    entry_t tail;
    logic   deq;

    assign out_valid = (count != '0);
    assign out_entry = head;
    assign deq       = out_valid & out_ready;

    // Enqueue at the tail, dequeue from the head, keep order across both.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            unique case ({in_valid, deq})
                2'b10: begin
                    if (count == 2'd0) head <= in_entry;
                    else               tail <= in_entry;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= in_entry;
                    end else begin
                        head <= tail;
                        tail <= in_entry;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a FWFT FIFO in sop/eop-framed bursts through a 2-entry skid buffer.
// Define FIFO_BURST_READER_TIMEOUT_EN to flush partial bursts after a timeout.
module fifo_burst_reader
    import fifo_burst_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 4,
    parameter int BURST_LEN      = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [ADDR_WIDTH:0]   fifo_depth,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_ren,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_sop,
    output logic                  m_eop,
    output logic                  busy
);

    localparam int RW = ADDR_WIDTH + 1;
    localparam logic [RW-1:0] BLEN = RW'(BURST_LEN);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  sop;
        logic                  eop;
    } entry_t;

    state_t                state;
    logic [RW-1:0]         rem;
    logic                  first;
    logic [SKID_CNT_W-1:0] skid_cnt;
    logic                  pop;
    logic                  start_full;
    logic                  flush;
    entry_t                in_e;
    entry_t                out_e;

    assign start_full = (fifo_depth >= BLEN);

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    localparam int TW = cnt_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tcnt;
    logic          pending;

    assign pending = (state == IDLE) & ~fifo_empty
                   & (fifo_depth != '0) & ~start_full;
    assign flush   = pending & (tcnt == TLAST);

    // Count idle cycles with a partial burst waiting; saturating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt <= '0;
        end else if (!pending || flush) begin
            tcnt <= '0;
        end else if (tcnt != TLAST) begin
            tcnt <= tcnt + 1'b1;
        end
    end
`else
    assign flush = 1'b0;
`endif

    // skid_cnt is registered, so m_ready never reaches fifo_ren.
    assign pop = (state == BURST) & (rem != '0) & ~fifo_empty
               & (skid_cnt < 2'd2);

    assign fifo_ren = pop;

    // Tag each popped word with its position in the burst.
    always_comb begin
        in_e      = '0;
        in_e.data = fifo_data;
        in_e.sop  = first;
        in_e.eop  = (rem == RW'(1));
    end

    // Burst FSM: capture length on entry, count pops down to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rem   <= '0;
            first <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    unique case (1'b1)
                        start_full: begin
                            state <= BURST;
                            rem   <= BLEN;
                            first <= 1'b1;
                        end
                        (flush & ~start_full): begin
                            state <= BURST;
                            rem   <= fifo_depth;
                            first <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                BURST: begin
                    if (pop) begin
                        rem   <= rem - RW'(1);
                        first <= 1'b0;
                        if (rem == RW'(1)) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fifo_skid_buf2 #(
        .entry_t (entry_t)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (pop),
        .in_entry  (in_e),
        .out_valid (m_valid),
        .out_entry (out_e),
        .out_ready (m_ready),
        .count     (skid_cnt)
    );

    assign m_data = out_e.data;
    assign m_sop  = out_e.sop;
    assign m_eop  = out_e.eop;
    assign busy   = (state == BURST) | (skid_cnt != '0);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: queue FIFO model, burst-framing reference.
// Covers both builds of FIFO_BURST_READER_TIMEOUT_EN.
module tb_fifo_burst_reader;

    localparam int DW  = 16;
    localparam int AW  = 4;
    localparam int DPW = AW + 1;
    localparam int BL  = 4;
    localparam int TO  = 16;
    localparam int CAP = 16;

    typedef struct {
        logic [DW-1:0] d;
        logic          s;
        logic          e;
    } word_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           fifo_empty = 1'b1;
    logic [DPW-1:0] fifo_depth = '0;
    logic [DW-1:0]  fifo_data = '0;
    logic           fifo_ren;
    logic           m_valid;
    logic           m_ready = 1'b0;
    logic [DW-1:0]  m_data;
    logic           m_sop;
    logic           m_eop;
    logic           busy;

    int checks = 0;
    int errors = 0;
    int pops = 0;
    int outstanding = 0;
    int rmode = 0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] wq[$];
    logic [DW-1:0] mq[$];
    word_t         expq[$];
    word_t         w;

    logic          prev_stall = 1'b0;
    logic [DW-1:0] pd = '0;
    logic          ps = 1'b0;
    logic          pe = 1'b0;

    fifo_burst_reader #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .BURST_LEN      (BL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_depth (fifo_depth),
        .fifo_data  (fifo_data),
        .fifo_ren   (fifo_ren),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_sop      (m_sop),
        .m_eop      (m_eop),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // FWFT FIFO: pop on fifo_ren, accept one write per cycle unless full.
    always @(posedge clk) begin
        if (fifo_ren && fq.size() > 0) begin
            void'(fq.pop_front());
            pops++;
        end
        if (wq.size() > 0 && fq.size() < CAP) fq.push_back(wq.pop_front());
        fifo_empty <= (fq.size() == 0);
        fifo_depth <= DPW'(fq.size());
        fifo_data  <= (fq.size() > 0) ? fq[0] : '0;
    end

    // Drive m_ready: 0 = held by the test, 1 = alternate, 2 = random.
    always @(posedge clk) begin
        #2;
        if (rmode == 1) m_ready = ~m_ready;
        else if (rmode == 2) m_ready = 1'($urandom_range(0, 1));
    end

    // Output monitor: stream contents, hold-while-stalled, skid limit.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall  = 1'b0;
            outstanding = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, pd);
                check("hold_tags", {m_sop, m_eop}, {ps, pe});
            end
            if (fifo_ren) check("ren_with_skid_full", outstanding < 2, 1);
            if (m_valid && m_ready) begin
                if (expq.size() == 0) begin
                    check("extra_word", m_data, 32'hFFFF_FFFF);
                end else begin
                    w = expq.pop_front();
                    check("data", m_data, w.d);
                    check("sop", m_sop, w.s);
                    check("eop", m_eop, w.e);
                end
            end
            outstanding += int'(fifo_ren) - int'(m_valid && m_ready);
            prev_stall = m_valid && !m_ready;
            pd = m_data;
            ps = m_sop;
            pe = m_eop;
        end
    end

    // Reference framing: words written in order, grouped BL at a time.
    task automatic model_burst();
        int n;
        n = mq.size();
        for (int i = 0; i < n; i++)
            expq.push_back('{d: mq[i], s: (i == 0), e: (i == n - 1)});
        mq.delete();
    endtask

    task automatic model_write(input logic [DW-1:0] d);
        mq.push_back(d);
        if (mq.size() == BL) model_burst();
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        wq.push_back(d);
        model_write(d);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drain(input string tag, input int lim);
        int k;
        k = 0;
        while ((expq.size() != 0 || wq.size() != 0) && k < lim) begin
            cyc(1);
            k++;
        end
        if (k >= lim) check({tag, "_drain_timeout"}, expq.size(), 0);
        cyc(3);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_valid_after"}, m_valid, 0);
        check({tag, "_fifo_left"}, fq.size(), mq.size());
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int k;
        int gap;
        int viol;
        int p0;
        int n;

        cyc(3);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_sop", m_sop, 0);
        check("rst_eop", m_eop, 0);
        check("rst_ren", fifo_ren, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        cyc(2);

        // Full burst with the sink always ready.
        m_ready = 1'b1;
        for (int i = 1; i <= 4; i++) write_word(DW'(16'h0100 + i));
        k = 0;
        while (!fifo_ren && k < 50) begin
            cyc(1);
            k++;
        end
        if (k >= 50) check("t1_ren_wait", 0, 1);
        for (int j = 0; j < 6; j++) begin
            check($sformatf("t1_ren_c%0d", j), fifo_ren, (j < 4));
            check($sformatf("t1_valid_c%0d", j), m_valid, (j >= 1 && j < 5));
            cyc(1);
        end
        drain("t1", 100);

`ifdef FIFO_BURST_READER_TIMEOUT_EN
        for (int i = 1; i <= 3; i++) write_word(DW'(16'hA000 + i));
        k = 0;
        gap = 0;
        while (!fifo_ren && k < 200) begin
            if (!fifo_empty) gap++;
            cyc(1);
            k++;
        end
        check("t2_timeout_gap", gap, TO);
        model_burst();
        drain("t2", 100);
`else
        for (int i = 1; i <= 3; i++) write_word(DW'(16'hA000 + i));
        viol = 0;
        repeat (100) begin
            if (m_valid || fifo_ren) viol++;
            cyc(1);
        end
        check("t6_partial_held", viol, 0);
        check("t6_depth", fifo_depth, 3);
        write_word(16'hA004);
        drain("t6", 100);
`endif

        // Two bursts with the sink alternating ready.
        rmode = 1;
        for (int i = 1; i <= 8; i++) write_word(DW'(i));
        drain("t3", 400);
        rmode = 0;
        m_ready = 1'b1;

        // Full FIFO with the sink stalled, then released.
        m_ready = 1'b0;
        cyc(1);
        p0 = pops;
        for (int i = 0; i < 16; i++) write_word(DW'(16'h4000 + i));
        cyc(36);
        check("t4_stalled_pops", pops - p0, 2);
        check("t4_stalled_valid", m_valid, 1);
        check("t4_stalled_head", m_data, 16'h4000);
        m_ready = 1'b1;
        drain("t4", 400);

        // Reset in the middle of a burst after two pops.
        m_ready = 1'b0;
        cyc(1);
        p0 = pops;
        for (int i = 1; i <= 6; i++) write_word(DW'(16'h5000 + i));
        k = 0;
        while ((pops - p0 < 2 || wq.size() != 0) && k < 100) begin
            cyc(1);
            k++;
        end
        check("t5_pops_before_reset", pops - p0, 2);
        reset = 1'b1;
        #1;
        check("t5_valid", m_valid, 0);
        check("t5_data", m_data, 0);
        check("t5_sop", m_sop, 0);
        check("t5_eop", m_eop, 0);
        check("t5_ren", fifo_ren, 0);
        check("t5_busy", busy, 0);
        expq.delete();
        mq.delete();
        foreach (fq[i]) model_write(fq[i]);
        cyc(2);
        reset = 1'b0;
        m_ready = 1'b1;
        drain("t5", 200);

        // Random traffic in multiples of the burst length.
        rmode = 2;
        for (int r = 0; r < 6; r++) begin
            n = BL * int'($urandom_range(1, 5));
            for (int i = 0; i < n; i++) write_word(DW'($urandom()));
            drain($sformatf("t7_r%0d", r), 1000);
        end
        rmode = 0;
        m_ready = 1'b1;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
